// File: rtl/npc_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : npc_sim_ctrl
// Description : Simulation-control block between the bench clock/reset and
//               the CPU core. Stretches reset into the core, counts RUN
//               cycles and retired instructions, captures the ebreak exit
//               code, and runs a global timeout plus a no-commit watchdog.
//               Optional commit-PC trace ring: NPC_SIM_CTRL_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_sim_ctrl #(
   parameter int XLEN           = 32,
   parameter int CNT_W          = 64,
   parameter int RST_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int HANG_CYCLES    = 4096,
   parameter int TRACE_DEPTH    = 16
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           i_commit_valid,
   input  logic [XLEN-1:0]                i_commit_pc,
   input  logic                           i_halt_req,
   input  logic [XLEN-1:0]                i_halt_code,
   output logic                           o_core_rstn,
   output logic                           o_done,
   output logic                           o_pass,
   output logic                           o_timeout,
   output logic [XLEN-1:0]                o_exit_code,
   output logic [CNT_W-1:0]               o_cycle_cnt,
   output logic [CNT_W-1:0]               o_instret_cnt,
   input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_rd_idx,
   output logic [XLEN-1:0]                o_trace_rd_pc,
   output logic [$clog2(TRACE_DEPTH):0]   o_trace_cnt
);

   typedef enum logic [1:0] {
      S_RST     = 2'd0,
      S_RUN     = 2'd1,
      S_HALT    = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   // Limits are compared as "last allowed value" so the transition happens
   // on the edge that completes the N-th cycle. A zero limit disables the
   // check, so the wrapped value of N-1 is never consulted.
   localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_HANG_LAST = CNT_W'(HANG_CYCLES - 1);
   localparam logic [31:0]      c_RST_LAST  = 32'(RST_CYCLES - 1);
   localparam bit               c_TO_EN     = (TIMEOUT_CYCLES != 0);
   localparam bit               c_HANG_EN   = (HANG_CYCLES != 0);

   state_t            r_state;
   logic [31:0]       r_rst_cnt;
   logic [CNT_W-1:0]  r_idle_cnt;
   logic [CNT_W-1:0]  r_cycle_cnt;
   logic [CNT_W-1:0]  r_instret_cnt;
   logic              r_core_rstn;
   logic              r_done;
   logic              r_pass;
   logic              r_timeout;
   logic [XLEN-1:0]   r_exit_code;

   logic [CNT_W-1:0]  w_cycle_nxt;
   logic [CNT_W-1:0]  w_instret_nxt;
   logic [CNT_W-1:0]  w_idle_nxt;
   logic              w_to_hit;
   logic              w_hang_hit;

   // Saturating increments and stop-condition detection for the RUN state
   assign w_cycle_nxt   = (r_cycle_cnt   == c_CNT_MAX) ? r_cycle_cnt   : r_cycle_cnt   + c_CNT_ONE;
   assign w_instret_nxt = (r_instret_cnt == c_CNT_MAX) ? r_instret_cnt : r_instret_cnt + c_CNT_ONE;
   assign w_idle_nxt    = (r_idle_cnt    == c_CNT_MAX) ? r_idle_cnt    : r_idle_cnt    + c_CNT_ONE;
   assign w_to_hit      = c_TO_EN && (r_cycle_cnt == c_TO_LAST);
   assign w_hang_hit    = c_HANG_EN && !i_commit_valid && (r_idle_cnt == c_HANG_LAST);

   // Control FSM: reset stretch, run accounting, terminal halt/timeout
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= S_RST;
         r_rst_cnt     <= '0;
         r_idle_cnt    <= '0;
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
         r_core_rstn   <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_timeout     <= 1'b0;
         r_exit_code   <= '0;
      end else begin
         case (r_state)
            S_RST: begin
               r_rst_cnt <= r_rst_cnt + 32'd1;
               if (r_rst_cnt == c_RST_LAST) begin
                  r_state     <= S_RUN;
                  r_core_rstn <= 1'b1;
               end
            end
            S_RUN: begin
               r_cycle_cnt <= w_cycle_nxt;
               if (i_commit_valid) begin
                  r_instret_cnt <= w_instret_nxt;
                  r_idle_cnt    <= '0;
               end else begin
                  r_idle_cnt    <= w_idle_nxt;
               end
               // A halt outranks both watchdogs firing on the same cycle
               if (i_halt_req) begin
                  r_state     <= S_HALT;
                  r_exit_code <= i_halt_code;
                  r_pass      <= (i_halt_code == '0);
                  r_done      <= 1'b1;
                  r_core_rstn <= 1'b0;
               end else if (w_to_hit || w_hang_hit) begin
                  r_state     <= S_TIMEOUT;
                  r_timeout   <= 1'b1;
                  r_done      <= 1'b1;
                  r_core_rstn <= 1'b0;
               end
            end
            default: begin
               // HALT / TIMEOUT: everything frozen until rstn
            end
         endcase
      end
   end

   assign o_core_rstn   = r_core_rstn;
   assign o_done        = r_done;
   assign o_pass        = r_pass;
   assign o_timeout     = r_timeout;
   assign o_exit_code   = r_exit_code;
   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;

`ifdef NPC_SIM_CTRL_TRACE_EN
   localparam int                 c_PTR_W      = $clog2(TRACE_DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
   localparam logic [c_PTR_W:0]   c_TRACE_FULL = (c_PTR_W + 1)'(TRACE_DEPTH);
   localparam logic [c_PTR_W:0]   c_TCNT_ONE   = (c_PTR_W + 1)'(1);

   logic [XLEN-1:0]    r_ring [TRACE_DEPTH];
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W:0]   r_trace_cnt;
   logic               w_trace_wr;
   logic [c_PTR_W-1:0] w_rd_ptr;

   // Only RUN-state commits are recorded, so the ring freezes on stop
   assign w_trace_wr = (r_state == S_RUN) && i_commit_valid;
   // Index 0 is the newest entry; power-of-two depth makes the wrap free
   assign w_rd_ptr   = r_wptr - c_PTR_ONE - i_trace_rd_idx;

   // Ring storage has no reset; stale entries are masked by trace_cnt
   always_ff @(posedge clk) begin
      if (w_trace_wr) begin
         r_ring[r_wptr] <= i_commit_pc;
      end
   end

   // Write pointer and saturating fill count
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr      <= '0;
         r_trace_cnt <= '0;
      end else if (w_trace_wr) begin
         r_wptr <= r_wptr + c_PTR_ONE;
         if (r_trace_cnt != c_TRACE_FULL) begin
            r_trace_cnt <= r_trace_cnt + c_TCNT_ONE;
         end
      end
   end

   assign o_trace_rd_pc = r_ring[w_rd_ptr];
   assign o_trace_cnt   = r_trace_cnt;
`else
   logic w_unused_trace;

   // Trace disabled: ports kept, driven constant, inputs sunk
   assign w_unused_trace = ^{i_trace_rd_idx, i_commit_pc};
   assign o_trace_rd_pc  = '0;
   assign o_trace_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npc_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_sim_ctrl
// Description : Self-checking bench for npc_sim_ctrl. RST_CYCLES=4,
//               TIMEOUT_CYCLES=20, HANG_CYCLES=8, TRACE_DEPTH=4.
//               Trace checks adapt to NPC_SIM_CTRL_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_sim_ctrl;

   localparam int XLEN  = 32;
   localparam int CNT_W = 64;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              commit_valid = 1'b0;
   logic [XLEN-1:0]   commit_pc = '0;
   logic              halt_req = 1'b0;
   logic [XLEN-1:0]   halt_code = '0;
   logic [1:0]        trace_rd_idx = '0;
   logic              core_rstn, done, pass, timeout;
   logic [XLEN-1:0]   exit_code, trace_rd_pc;
   logic [CNT_W-1:0]  cycle_cnt, instret_cnt;
   logic [2:0]        trace_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   npc_sim_ctrl #(
      .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(4),
      .TIMEOUT_CYCLES(20), .HANG_CYCLES(8), .TRACE_DEPTH(4)
   ) dut (
      .clk(clk), .rstn(rstn),
      .i_commit_valid(commit_valid), .i_commit_pc(commit_pc),
      .i_halt_req(halt_req), .i_halt_code(halt_code),
      .o_core_rstn(core_rstn), .o_done(done), .o_pass(pass),
      .o_timeout(timeout), .o_exit_code(exit_code),
      .o_cycle_cnt(cycle_cnt), .o_instret_cnt(instret_cnt),
      .i_trace_rd_idx(trace_rd_idx), .o_trace_rd_pc(trace_rd_pc),
      .o_trace_cnt(trace_cnt)
   );

   typedef struct {
      logic        commit;
      logic [31:0] pc;
      logic        halt;
      logic [31:0] code;
      logic        e_crst, e_done, e_pass, e_to;
      logic [31:0] e_exit;
      logic [63:0] e_cyc, e_inst;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_crst, input logic e_done,
                          input logic e_pass, input logic e_to, input logic [31:0] e_exit,
                          input logic [63:0] e_cyc, input logic [63:0] e_inst);
      chk({tag, ".core_rstn"}, 64'(core_rstn), 64'(e_crst));
      chk({tag, ".done"},      64'(done),      64'(e_done));
      chk({tag, ".pass"},      64'(pass),      64'(e_pass));
      chk({tag, ".timeout"},   64'(timeout),   64'(e_to));
      chk({tag, ".exit_code"}, 64'(exit_code), 64'(e_exit));
      chk({tag, ".cycle_cnt"}, cycle_cnt,      e_cyc);
      chk({tag, ".instret"},   instret_cnt,    e_inst);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic [31:0] pc, input logic h, input logic [31:0] code);
      commit_valid = c;
      commit_pc    = pc;
      halt_req     = h;
      halt_code    = code;
   endtask

   // Hold reset across an edge, check reset values, release and check the
   // core reset rises exactly on the 4th edge
   task automatic do_reset(input string tag);
      drive(1'b0, '0, 1'b0, '0);
      rstn = 1'b0;
      tick();
      chk_all({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      chk({tag, ".rst.trace_cnt"}, 64'(trace_cnt), 64'd0);
      rstn = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 32'hDEAD0000, 1'b1, 32'h1); // ignored in RST
         tick();
      end
      chk_all({tag, ".edge3"}, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      chk_all({tag, ".edge4"}, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] e_tpc;
      logic [2:0]  e_tcnt;

      // 10 commits over 12 cycles, then halt with code 0, then ignored inputs
      vecs[0]  = '{1'b1, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd1,  64'd1};
      vecs[1]  = '{1'b1, 32'h80000004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd2,  64'd2};
      vecs[2]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd3,  64'd2};
      vecs[3]  = '{1'b1, 32'h80000008, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd4,  64'd3};
      vecs[4]  = '{1'b1, 32'h8000000C, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd5,  64'd4};
      vecs[5]  = '{1'b1, 32'h80000010, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd6,  64'd5};
      vecs[6]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd7,  64'd5};
      vecs[7]  = '{1'b1, 32'h80000014, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd8,  64'd6};
      vecs[8]  = '{1'b1, 32'h80000018, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd9,  64'd7};
      vecs[9]  = '{1'b1, 32'h8000001C, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd10, 64'd8};
      vecs[10] = '{1'b1, 32'h80000020, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd11, 64'd9};
      vecs[11] = '{1'b1, 32'h80000024, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'd12, 64'd10};
      vecs[12] = '{1'b0, 32'h0,        1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 64'd13, 64'd10};
      vecs[13] = '{1'b1, 32'h80000028, 1'b1, 32'h7, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 64'd13, 64'd10};

      // Reset sequence and table-driven run to halt with exit code 0
      do_reset("A");
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].commit, vecs[i].pc, vecs[i].halt, vecs[i].code);
         tick();
         chk_all($sformatf("A.v%0d", i), vecs[i].e_crst, vecs[i].e_done, vecs[i].e_pass,
                 vecs[i].e_to, vecs[i].e_exit, vecs[i].e_cyc, vecs[i].e_inst);
      end

      // Halt with non-zero code, same-cycle commit still counted
      do_reset("B");
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h80000000, 1'b0, '0);
         tick();
      end
      drive(1'b1, 32'h80000008, 1'b1, 32'h5);
      tick();
      chk_all("B.halt5", 1'b0, 1'b1, 1'b0, 1'b0, 32'h5, 64'd3, 64'd3);

      // Hang watchdog: 3 commits then silence, fires on the 8th idle cycle
      do_reset("C");
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h80000000, 1'b0, '0);
         tick();
      end
      drive(1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 7; i++) tick();
      chk_all("C.idle7", 1'b1, 1'b0, 1'b0, 1'b0, '0, 64'd10, 64'd3);
      tick();
      chk_all("C.idle8", 1'b0, 1'b1, 1'b0, 1'b1, '0, 64'd11, 64'd3);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h1, 1'b1, 32'h9);
         tick();
      end
      chk_all("C.frozen", 1'b0, 1'b1, 1'b0, 1'b1, '0, 64'd11, 64'd3);

      // Global timeout with continuous commits, decided at cycle_cnt=19
      do_reset("D");
      drive(1'b1, 32'h80000000, 1'b0, '0);
      for (int i = 0; i < 19; i++) tick();
      chk_all("D.c19", 1'b1, 1'b0, 1'b0, 1'b0, '0, 64'd19, 64'd19);
      tick();
      chk_all("D.to", 1'b0, 1'b1, 1'b0, 1'b1, '0, 64'd20, 64'd20);

      // Halt in the same cycle the global timeout fires: halt wins
      do_reset("E");
      drive(1'b1, 32'h80000000, 1'b0, '0);
      for (int i = 0; i < 19; i++) tick();
      drive(1'b1, 32'h80000000, 1'b1, 32'h2A);
      tick();
      chk_all("E.halt_vs_to", 1'b0, 1'b1, 1'b0, 1'b0, 32'h2A, 64'd20, 64'd20);

      // rstn pulsed mid-RUN: asynchronous clear, then RST sequence restarts
      do_reset("F");
      drive(1'b1, 32'h80000000, 1'b0, '0);
      for (int i = 0; i < 5; i++) tick();
      chk_all("F.run5", 1'b1, 1'b0, 1'b0, 1'b0, '0, 64'd5, 64'd5);
      rstn = 1'b0;
      #2;
      chk_all("F.async", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      do_reset("F2");

      // Commit-PC trace ring: 6 commits into a 4-deep ring
      do_reset("G");
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 32'h80000000 + 32'(4 * k), 1'b0, '0);
         tick();
      end
      drive(1'b0, '0, 1'b1, '0);
      tick();
      drive(1'b1, 32'h12345678, 1'b0, '0); // halted: must not be recorded
      tick();
      drive(1'b0, '0, 1'b0, '0);
`ifdef NPC_SIM_CTRL_TRACE_EN
      e_tcnt = 3'd4;
`else
      e_tcnt = 3'd0;
`endif
      chk("G.trace_cnt", 64'(trace_cnt), 64'(e_tcnt));
      for (int j = 0; j < 4; j++) begin
         trace_rd_idx = 2'(j);
`ifdef NPC_SIM_CTRL_TRACE_EN
         e_tpc = 32'h80000014 - 32'(4 * j);
`else
         e_tpc = 32'h0;
`endif
         #1;
         chk($sformatf("G.trace_idx%0d", j), 64'(trace_rd_pc), 64'(e_tpc));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/npc_sim_ctrl.md
Name: npc_sim_ctrl

Overview:
Parametrised simulation-control block for the Verilator top level. It sits between the testbench clock/reset and the CPU core and does the following:
- Stretches reset into the core.
- Counts cycles and retired instructions.
- Detects the ebreak halt and captures the exit code.
- Runs a global timeout and a no-commit (hang) watchdog.
The C++ harness polls its outputs to end the simulation and report pass/fail.

Parameters:
XLEN, 32, width of commit PC and halt exit code
CNT_W, 64, width of cycle and instret counters (saturating)
RST_CYCLES, 16, cycles core_rstn is held low after rstn deasserts (legal >= 1)
TIMEOUT_CYCLES, 1000000, max RUN cycles before forced stop; 0 disables
HANG_CYCLES, 4096, max consecutive RUN cycles without commit; 0 disables
TRACE_DEPTH, 16, commit-PC ring depth (power of two, used only with trace feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
commit_valid  input  1  core retired one instruction this cycle
commit_pc  input  XLEN  PC of retired instruction, valid with commit_valid
halt_req  input  1  core committed ebreak this cycle
halt_code  input  XLEN  value of a0 at ebreak, valid with halt_req
core_rstn  output  1  registered active-low reset to the core
done  output  1  simulation finished (HALT or TIMEOUT)
pass  output  1  halted with exit code 0
timeout  output  1  stopped by timeout or hang watchdog
exit_code  output  XLEN  captured halt_code
cycle_cnt  output  CNT_W  RUN cycles elapsed
instret_cnt  output  CNT_W  instructions retired
trace_rd_idx  input  $clog2(TRACE_DEPTH)  trace read index (0 = newest)
trace_rd_pc  output  XLEN  PC at trace_rd_idx
trace_cnt  output  $clog2(TRACE_DEPTH)+1  valid trace entries

Behaviour:
States: RST, RUN, HALT, TIMEOUT. All outputs are registered except trace_rd_pc.

Reset (rstn low, asynchronous):
- State = RST.
- core_rstn = 0, done = 0, pass = 0, timeout = 0.
- exit_code = 0, cycle_cnt = 0, instret_cnt = 0.
- Internal rst_cnt = 0, idle_cnt = 0, trace_cnt = 0, trace write pointer = 0.

RST:
- rst_cnt increments each clock.
- At rst_cnt == RST_CYCLES-1, go to RUN and set core_rstn = 1 on the same edge.
- core_rstn therefore rises on the RST_CYCLES-th rising edge after rstn deasserts.
- All core inputs are ignored in RST.

RUN:
- cycle_cnt increments every cycle.
- instret_cnt increments when commit_valid = 1.
- Both counters saturate at all-ones.
- idle_cnt clears on commit_valid; otherwise it increments.

Transitions out of RUN, evaluated each cycle in this priority order (highest first):
1. halt_req = 1:
   - Go to HALT.
   - exit_code <= halt_code; pass <= (halt_code == 0); done <= 1.
   - A commit_valid in the same cycle is still counted.
2. TIMEOUT_CYCLES != 0 and cycle_cnt == TIMEOUT_CYCLES-1:
   - Go to TIMEOUT; timeout <= 1, done <= 1, pass stays 0.
3. HANG_CYCLES != 0, commit_valid = 0 and idle_cnt == HANG_CYCLES-1:
   - Go to TIMEOUT, same outputs as 2.

HALT and TIMEOUT:
- Terminal states; exited only via rstn.
- core_rstn <= 0 on entry, freezing the core.
- Counters, exit_code, pass and timeout hold their values.
- halt_req and commit_valid are ignored.

Reset mid-operation:
- rstn low in any state immediately restores every reset value above.

Width rules:
- Counter comparisons against parameters are zero-extended to CNT_W.

Optional Feature:
Macro NPC_SIM_CTRL_TRACE_EN.

Defined:
- Each RUN-state commit_valid writes commit_pc into a TRACE_DEPTH-entry ring at the write pointer, then the pointer increments and wraps.
- trace_cnt increments, saturating at TRACE_DEPTH.
- trace_rd_pc is the combinational read of entry (wptr-1-trace_rd_idx) mod TRACE_DEPTH.
- Ring contents are not reset; only wptr and trace_cnt are.
- Ring is frozen in HALT and TIMEOUT.

Undefined:
- No storage is instantiated.
- trace_rd_pc = 0 and trace_cnt = 0 constantly.
- Ports remain present so the top level is unchanged.

Test Plan:
1. RST_CYCLES=4: deassert rstn -> core_rstn rises on 4th edge; cycle_cnt=0 until then.
2. RUN: 10 commits over 12 cycles, then halt_req with halt_code=0 -> done=1, pass=1, exit_code=0, instret_cnt=10, core_rstn=0 next cycle.
3. halt_req with halt_code=5 -> pass=0, exit_code=5, timeout=0.
4. HANG_CYCLES=8 with no commits after 3 -> TIMEOUT entered after 8 idle cycles; timeout=1, done=1, pass=0. Separately, TIMEOUT_CYCLES=20 with continuous commits -> TIMEOUT when cycle_cnt=19.
5. halt_req in the same cycle the global timeout fires -> HALT wins: timeout=0, exit_code captured. Separately, rstn pulsed low mid-RUN -> all outputs return to reset values and the RST sequence restarts.
6. NPC_SIM_CTRL_TRACE_EN, TRACE_DEPTH=4: commit PCs 0x80000000..0x80000014 (6 commits) -> trace_cnt=4; idx0=0x80000014, idx3=0x80000008.
